g_3arb: RTL

Three-requester round-robin arbiter for the schematic macro library. It shares one downstream resource between two active-low requesters (AN, BN) and one active-high requester (C). This is the same polarity mix the library's request-merge OR gate combines. The block issues one-hot registered grants, holds a grant until the owner drops its request, and inserts one dead cycle between owners. It sits between the request-merge logic and the shared resource in schematic designs.

---
 rtl/g_3arb_if.sv | 37 +++
 rtl/g_3arb.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/g_3arb_if.sv
// Request/grant bundle between the request-merge logic and the g_3arb arbiter.
// AN/BN are active-low requests; C and all outputs are active-high.
interface g_3arb_if;
   logic AN;
   logic BN;
   logic C;
   logic GA;
   logic GB;
   logic GC;
   logic Y;
   logic BUSY;
   logic TO;

   modport master (
      output AN,
      output BN,
      output C,
      input  GA,
      input  GB,
      input  GC,
      input  Y,
      input  BUSY,
      input  TO
   );

   modport slave (
      input  AN,
      input  BN,
      input  C,
      output GA,
      output GB,
      output GC,
      output Y,
      output BUSY,
      output TO
   );
endinterface

// File: rtl/g_3arb.sv
// Three-requester round-robin arbiter with registered one-hot grants and a dead cycle
// between owners. Define G_3ARB_TIMEOUT_EN to build the HOLD_MAX grant-hold timeout.
module g_3arb #(
   parameter int unsigned HOLD_MAX = 15
) (
   input logic   CK,
   input logic   CDN,
   g_3arb_if.slave bus
);

   typedef enum logic [1:0] {StIdle, StGrant, StDead} state_e;

   localparam logic [1:0] OwnA = 2'd0;
   localparam logic [1:0] OwnB = 2'd1;
   localparam logic [1:0] OwnC = 2'd2;

   logic [2:0] req;
   logic       owner_req;
   logic       timeout_hit;
   logic       pick_vld;
   logic [1:0] pick_idx;

   state_e     state_q, state_d;
   logic [1:0] ptr_q, ptr_d;
   logic [2:0] grant_q, grant_d;
   logic       y_q;
   logic       run_q;

   assign req = {bus.C, ~bus.BN, ~bus.AN};

   // Search starts just after the last owner: A->B->C->A.
   always_comb begin
      pick_vld = 1'b0;
      pick_idx = OwnA;
      unique case (ptr_q)
         OwnA: begin
            if      (req[1]) begin pick_vld = 1'b1; pick_idx = OwnB; end
            else if (req[2]) begin pick_vld = 1'b1; pick_idx = OwnC; end
            else if (req[0]) begin pick_vld = 1'b1; pick_idx = OwnA; end
         end
         OwnB: begin
            if      (req[2]) begin pick_vld = 1'b1; pick_idx = OwnC; end
            else if (req[0]) begin pick_vld = 1'b1; pick_idx = OwnA; end
            else if (req[1]) begin pick_vld = 1'b1; pick_idx = OwnB; end
         end
         default: begin
            if      (req[0]) begin pick_vld = 1'b1; pick_idx = OwnA; end
            else if (req[1]) begin pick_vld = 1'b1; pick_idx = OwnB; end
            else if (req[2]) begin pick_vld = 1'b1; pick_idx = OwnC; end
         end
      endcase
   end

   // While granted, the pointer always names the current owner.
   always_comb begin
      owner_req = 1'b0;
      unique case (ptr_q)
         OwnA:    owner_req = req[0];
         OwnB:    owner_req = req[1];
         OwnC:    owner_req = req[2];
         default: owner_req = 1'b0;
      endcase
   end

`ifdef G_3ARB_TIMEOUT_EN
   localparam logic [7:0] HoldLast = 8'(HOLD_MAX - 1);

   logic [7:0] cnt_q, cnt_d;
   logic       to_q, to_d;

   assign timeout_hit = (cnt_q == HoldLast);

   always_comb begin
      cnt_d = cnt_q;
      to_d  = 1'b0;
      unique case (state_q)
         StIdle:  cnt_d = 8'd0;
         StGrant: begin
            cnt_d = cnt_q + 8'd1;
            to_d  = owner_req && timeout_hit;
         end
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge CK or negedge CDN) begin
      if (!CDN) begin
         cnt_q <= 8'd0;
         to_q  <= 1'b0;
      end else if (run_q) begin
         cnt_q <= cnt_d;
         to_q  <= to_d;
      end
   end

   assign bus.TO = to_q;
`else
   assign timeout_hit = 1'b0;
   assign bus.TO      = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      grant_d = grant_q;
      unique case (state_q)
         StIdle: begin
            grant_d = 3'b000;
            if (pick_vld) begin
               state_d = StGrant;
               ptr_d   = pick_idx;
               grant_d = 3'b001 << pick_idx;
            end
         end
         StGrant: begin
            if (!owner_req || timeout_hit) begin
               state_d = StDead;
               grant_d = 3'b000;
            end
         end
         StDead: begin
            state_d = StIdle;
            grant_d = 3'b000;
         end
         default: begin
            state_d = StIdle;
            grant_d = 3'b000;
         end
      endcase
   end

   // run_q holds the FSM for the first edge after reset release.
   always_ff @(posedge CK or negedge CDN) begin
      if (!CDN) begin
         state_q <= StIdle;
         ptr_q   <= OwnC;
         grant_q <= 3'b000;
         y_q     <= 1'b0;
         run_q   <= 1'b0;
      end else begin
         y_q   <= |req;
         run_q <= 1'b1;
         if (run_q) begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
         end
      end
   end

   assign bus.GA   = grant_q[0];
   assign bus.GB   = grant_q[1];
   assign bus.GC   = grant_q[2];
   assign bus.Y    = y_q;
   assign bus.BUSY = (state_q != StIdle);

endmodule
